// File: rtl/rf_arb_pkg.sv
// rtl/rf_arb_pkg.sv - shared types and defaults for the register-file port arbiter
package rf_arb_pkg;

    localparam int RF_DW = 8;
    localparam int RF_AW = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    typedef logic client_id_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin picker
module rr_arb2
    import rf_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = 1'b0;
        // On a tie the client that was not served last goes next.
        if (req == 2'b11) begin
            gnt_id = ~last;
        end else if (req[1]) begin
            gnt_id = 1'b1;
        end
    end

endmodule

// File: rtl/rf_port_arbiter.sv
// rtl/rf_port_arbiter.sv - serialises two req/ack clients onto one 1R1W register file
module rf_port_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DW = RF_DW,
    parameter int AW = RF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          wr0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          wr1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] rf_ra,
    output logic [AW-1:0] rf_wa,
    output logic          rf_we,
    output logic [DW-1:0] rf_din,
    input  logic [DW-1:0] rf_dout,
    output logic          busy
);

    state_t     state;
    state_t     state_nxt;
    client_id_t last_grant;
    client_id_t cmd_id;
    logic       cmd_wr;
    logic       gnt_valid;
    client_id_t gnt_id;

    logic          sel_wr;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    rr_arb2 u_rr_arb2 (
        .req       ({req1, req0}),
        .last      (last_grant),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    assign sel_wr    = gnt_id ? wr1    : wr0;
    assign sel_addr  = gnt_id ? addr1  : addr0;
    assign sel_wdata = gnt_id ? wdata1 : wdata0;

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_valid) state_nxt = ACCESS;
            ACCESS:  state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The rf pins are loaded on the IDLE->ACCESS edge so they are stable
    // registers for the whole ACCESS cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            cmd_id     <= 1'b0;
            cmd_wr     <= 1'b0;
            rf_we      <= 1'b0;
            rf_ra      <= '0;
            rf_wa      <= '0;
            rf_din     <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            rf_we <= 1'b0;
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        cmd_id <= gnt_id;
                        cmd_wr <= sel_wr;
                        if (sel_wr) begin
                            rf_we  <= 1'b1;
                            rf_wa  <= sel_addr;
                            rf_din <= sel_wdata;
                        end else begin
                            rf_ra  <= sel_addr;
                        end
                    end
                end
                ACCESS: begin
                    if (!cmd_wr) begin
                        if (cmd_id) rdata1 <= rf_dout;
                        else        rdata0 <= rf_dout;
                    end
                    if (cmd_id) ack1 <= 1'b1;
                    else        ack0 <= 1'b1;
                end
                ACK: begin
                    last_grant <= cmd_id;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_port_arbiter.sv
// tb/tb_rf_port_arbiter.sv - directed bench with a transaction-level reference model
module tb_rf_port_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, wr0 = 1'b0, req1 = 1'b0, wr1 = 1'b0;
    logic [2:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    logic       ack0, ack1, rf_we, busy;
    logic [7:0] rdata0, rdata1, rf_din, rf_dout;
    logic [2:0] rf_ra, rf_wa;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_port_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .rf_ra(rf_ra), .rf_wa(rf_wa), .rf_we(rf_we), .rf_din(rf_din), .rf_dout(rf_dout),
        .busy(busy)
    );

    // Register file instance driven purely by the DUT pins.
    logic [7:0] rf_mem [8];
    initial begin
        for (int i = 0; i < 8; i++) rf_mem[i] = 8'h00;
        rf_mem[7] = 8'h3C;
    end
    always @(posedge clk) if (rf_we) rf_mem[rf_wa] <= rf_din;
    assign rf_dout = rf_mem[rf_ra];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: one operation in flight, tracked by edge distance from its grant.
    int         cyc = 0;
    bit         started = 0;
    bit         op_active = 0;
    int         op_edge = 0;
    int         op_id = 0;
    bit         op_wr = 0;
    int         op_addr = 0;
    int         op_wdata = 0;
    int         m_last = 1;
    int         m_rdata [2] = '{0, 0};
    int         ref_mem [8] = '{0, 0, 0, 0, 0, 0, 0, 8'h3C};

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            started   = 1;
            op_active = 0;
            m_last    = 1;
            m_rdata   = '{0, 0};
        end else if (op_active && cyc - op_edge == 2) begin
            op_active = 0;
            m_last    = op_id;
        end else if (op_active && cyc - op_edge == 1) begin
            if (op_wr) ref_mem[op_addr] = op_wdata;
            else       m_rdata[op_id] = ref_mem[op_addr];
        end else if (!op_active && (req0 || req1)) begin
            op_id     = (req0 && req1) ? 1 - m_last : (req1 ? 1 : 0);
            op_wr     = op_id ? wr1 : wr0;
            op_addr   = op_id ? int'(addr1) : int'(addr0);
            op_wdata  = op_id ? int'(wdata1) : int'(wdata0);
            op_active = 1;
            op_edge   = cyc;
        end
    end

    int ack_id_q [$];
    int ack_cyc_q [$];
    int we_cnt = 0;
    int last_wa = 0;
    int last_din = 0;

    always @(negedge clk) begin
        if (started) begin
            int k;
            k = cyc - op_edge;
            chk("busy", int'(busy), int'(op_active));
            chk("ack0", int'(ack0), int'(op_active && k == 1 && op_id == 0));
            chk("ack1", int'(ack1), int'(op_active && k == 1 && op_id == 1));
            chk("rf_we", int'(rf_we), int'(op_active && k == 0 && op_wr));
            chk("rdata0", int'(rdata0), m_rdata[0]);
            chk("rdata1", int'(rdata1), m_rdata[1]);
            if (op_active && k == 0 && op_wr) begin
                chk("rf_wa", int'(rf_wa), op_addr);
                chk("rf_din", int'(rf_din), op_wdata);
            end
            if (op_active && k == 0 && !op_wr) chk("rf_ra", int'(rf_ra), op_addr);
            if (rf_we) begin
                we_cnt++;
                last_wa  = int'(rf_wa);
                last_din = int'(rf_din);
            end
            if (ack0) begin ack_id_q.push_back(0); ack_cyc_q.push_back(cyc); end
            if (ack1) begin ack_id_q.push_back(1); ack_cyc_q.push_back(cyc); end
        end
    end

    task automatic do_op(input int id, input logic w, input logic [2:0] a, input logic [7:0] d,
                         output int lat, output int ack_at, output int rd);
        lat = -1;
        ack_at = -1;
        if (id == 0) begin req0 = 1; wr0 = w; addr0 = a; wdata0 = d; end
        else         begin req1 = 1; wr1 = w; addr1 = a; wdata1 = d; end
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if ((id == 0 && ack0) || (id == 1 && ack1)) begin
                lat = i;
                ack_at = cyc;
                break;
            end
        end
        rd = (id == 0) ? int'(rdata0) : int'(rdata1);
        if (id == 0) req0 = 0; else req1 = 0;
        chk("op_ack_seen", int'(lat > 0), 1);
    endtask

    task automatic do_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
    endtask

    int lat_a, lat_b, cyc_a, cyc_b, rd_a, rd_b, n, base;

    initial begin
        do_reset();
        chk("rst_ack0", int'(ack0), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rdata0", int'(rdata0), 0);
        chk("rst_rdata1", int'(rdata1), 0);
        chk("rst_rf_ra", int'(rf_ra), 0);
        chk("rst_rf_wa", int'(rf_wa), 0);
        chk("rst_rf_din", int'(rf_din), 0);
        repeat (5) @(posedge clk);
        #1;

        // Client 0 write then read back addr 3.
        we_cnt = 0;
        do_op(0, 1'b1, 3'd3, 8'hA5, lat_a, cyc_a, rd_a);
        chk("wr_latency", lat_a, 2);
        chk("wr_we_cycles", we_cnt, 1);
        chk("wr_wa", last_wa, 3);
        chk("wr_din", last_din, 8'hA5);
        @(posedge clk); #1;
        do_op(0, 1'b0, 3'd3, 8'h00, lat_a, cyc_a, rd_a);
        chk("rd_latency", lat_a, 2);
        chk("rd_data0", rd_a, 8'hA5);
        @(posedge clk); #1;

        // Tie straight after reset: client 0 first, client 1 sees its write.
        do_reset();
        fork
            do_op(0, 1'b1, 3'd1, 8'h11, lat_a, cyc_a, rd_a);
            do_op(1, 1'b0, 3'd1, 8'h00, lat_b, cyc_b, rd_b);
        join
        chk("tie_first_lat0", lat_a, 2);
        chk("tie_gap", cyc_b - cyc_a, 3);
        chk("tie_rdata1", rd_b, 8'h11);
        @(posedge clk); #1;

        // Both held for 8 operations.
        ack_id_q.delete();
        ack_cyc_q.delete();
        req0 = 1; wr0 = 0; addr0 = 3'd1;
        req1 = 1; wr1 = 1; addr1 = 3'd2; wdata1 = 8'h5A;
        n = 0;
        for (int i = 0; i < 60 && n < 8; i++) begin
            @(posedge clk); #1;
            if (ack0 || ack1) n++;
        end
        req0 = 0; req1 = 0;
        @(posedge clk); #1;
        chk("rr_count", ack_id_q.size(), 8);
        for (int i = 0; i < 8 && i < ack_id_q.size(); i++) begin
            chk("rr_order", ack_id_q[i], i % 2);
            if (i > 0) chk("rr_spacing", ack_cyc_q[i] - ack_cyc_q[i-1], 3);
        end
        chk("rr_rdata0", int'(rdata0), 8'h11);

        // Client 1 reads addr 7 alone; client 0 keeps its data.
        do_op(1, 1'b0, 3'd7, 8'h00, lat_b, cyc_b, rd_b);
        chk("c1_rdata1", rd_b, 8'h3C);
        chk("c1_rdata0_kept", int'(rdata0), 8'h11);
        @(posedge clk); #1;
        do_op(0, 1'b0, 3'd3, 8'h00, lat_a, cyc_a, rd_a);
        chk("c0_rd3", rd_a, 8'hA5);
        @(posedge clk); #1;

        // Reset during ACCESS of a client 1 read.
        base = ack_id_q.size();
        req1 = 1; wr1 = 0; addr1 = 3'd7;
        @(posedge clk); #1;
        chk("abort_busy", int'(busy), 1);
        req1 = 0;
        rst = 1;
        @(posedge clk); #1;
        chk("abort_busy_rst", int'(busy), 0);
        chk("abort_ack1", int'(ack1), 0);
        chk("abort_rdata0", int'(rdata0), 0);
        chk("abort_rdata1", int'(rdata1), 0);
        chk("abort_rf_ra", int'(rf_ra), 0);
        chk("abort_rf_we", int'(rf_we), 0);
        rst = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_ack", ack_id_q.size() - base, 0);
        fork
            do_op(0, 1'b0, 3'd7, 8'h00, lat_a, cyc_a, rd_a);
            do_op(1, 1'b0, 3'd3, 8'h00, lat_b, cyc_b, rd_b);
        join
        chk("post_rst_tie_lat0", lat_a, 2);
        chk("post_rst_gap", cyc_b - cyc_a, 3);
        chk("post_rst_rd0", rd_a, 8'h3C);
        chk("post_rst_rd1", rd_b, 8'hA5);
        repeat (3) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=%0d required=done", cyc);
        $fatal(1);
    end

endmodule
